// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: evaluates conditional branches, JAL and JALR,
// flags mispredicts against the fetch prediction, and owns a 2-bit counter BHT.
module branch_resolve_unit #(
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 32,
  parameter int BhtEntries  = 64,
  parameter int BhtIndexLsb = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [1:0]           in_kind,
  input  logic [2:0]           in_fun3,
  input  logic [DataWidth-1:0] operand_a,
  input  logic [DataWidth-1:0] operand_b,
  input  logic [AddrWidth-1:0] in_pc,
  input  logic [AddrWidth-1:0] in_imm,
  input  logic                 in_pred_taken,
  input  logic [AddrWidth-1:0] in_pred_target,
  input  logic                 in_stall,
  input  logic                 in_flush,
  input  logic [AddrWidth-1:0] lk_pc,
  output logic                 lk_taken,
  output logic                 out_valid,
  output logic                 out_taken,
  output logic [AddrWidth-1:0] out_target,
  output logic [AddrWidth-1:0] out_link,
  output logic                 out_mispredict,
  output logic [AddrWidth-1:0] out_redirect_pc,
  output logic                 out_illegal
);

  localparam int IdxW = $clog2(BhtEntries);

  localparam logic [1:0] KindCond = 2'b00;
  localparam logic [1:0] KindJal  = 2'b01;
  localparam logic [1:0] KindJalr = 2'b10;

  // Stage handshake: an instruction is accepted on a rising edge when in_valid=1,
  // in_stall=0 and in_flush=0. Flush clears out_valid and wins over stall; stall
  // freezes every output and the BHT. There is no backpressure on the output side.
  logic accept;
  assign accept = !in_flush && !in_stall;

  logic [1:0] bht [BhtEntries];

  logic [IdxW-1:0] lk_idx, upd_idx;
  assign lk_idx  = lk_pc[BhtIndexLsb +: IdxW];
  assign upd_idx = in_pc[BhtIndexLsb +: IdxW];

  // Lookup sees the registered counter, so a same-cycle update is not bypassed.
  assign lk_taken = bht[lk_idx][1];

  logic cond, fun3_legal;
  always_comb begin
    cond       = 1'b0;
    fun3_legal = 1'b1;
    case (in_fun3)
      3'b000:  cond = (operand_a == operand_b);
      3'b001:  cond = (operand_a != operand_b);
      3'b100:  cond = ($signed(operand_a) <  $signed(operand_b));
      3'b101:  cond = ($signed(operand_a) >= $signed(operand_b));
      3'b110:  cond = (operand_a <  operand_b);
      3'b111:  cond = (operand_a >= operand_b);
      default: fun3_legal = 1'b0;
    endcase
  end

  logic                 is_cond, illegal, taken, mispredict;
  logic [AddrWidth-1:0] link, rel_target, jalr_target, target, redirect_pc;

  assign is_cond    = (in_kind == KindCond);
  assign illegal    = (in_kind == 2'b11) || (is_cond && !fun3_legal);
  assign taken      = is_cond ? (fun3_legal && cond)
                              : (in_kind == KindJal || in_kind == KindJalr);
  assign link       = in_pc + AddrWidth'(4);
  assign rel_target = in_pc + in_imm;
  // The low AddrWidth bits of a DataWidth sum depend only on the low operand bits,
  // so sign-extending the immediate to DataWidth first would not change the result.
  assign jalr_target = (operand_a[AddrWidth-1:0] + in_imm) & ~AddrWidth'(1);
  assign target      = (in_kind == KindJalr) ? jalr_target : rel_target;
  assign mispredict  = (taken != in_pred_taken) || (taken && target != in_pred_target);
  assign redirect_pc = taken ? target : link;

  logic bht_update;
  assign bht_update = accept && in_valid && is_cond && fun3_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_taken       <= 1'b0;
      out_target      <= '0;
      out_link        <= '0;
      out_mispredict  <= 1'b0;
      out_redirect_pc <= '0;
      out_illegal     <= 1'b0;
      for (int i = 0; i < BhtEntries; i++) bht[i] <= 2'b01;
    end else if (in_flush) begin
      out_valid <= 1'b0;
    end else if (!in_stall) begin
      out_valid       <= in_valid;
      out_taken       <= taken;
      out_target      <= target;
      out_link        <= link;
      out_mispredict  <= mispredict;
      out_redirect_pc <= redirect_pc;
      out_illegal     <= illegal;
      if (bht_update) begin
        if (cond && bht[upd_idx] != 2'b11)
          bht[upd_idx] <= bht[upd_idx] + 2'b01;
        else if (!cond && bht[upd_idx] != 2'b00)
          bht[upd_idx] <= bht[upd_idx] - 2'b01;
      end
    end
  end

  // Only the index bits of lk_pc take part in the lookup.
  logic unused_bits;
  assign unused_bits = ^{lk_pc, operand_a};

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised, registered branch resolution unit for the execute stage. It evaluates conditional branches, JAL and JALR, and computes the target and link address. It compares the outcome against the fetch-stage prediction and raises a redirect on mispredict. It owns a 2-bit saturating-counter branch history table (BHT), which fetch reads through a combinational lookup port.

Parameters:
DataWidth, 32, operand width for compares and the JALR base
AddrWidth, 32, PC/target width; must be <= DataWidth
BhtEntries, 64, number of BHT counters; power of two, >= 2
BhtIndexLsb, 2, lowest PC bit used for the BHT index

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  a branch/jump instruction is presented this cycle
in_kind  input  2  00 conditional, 01 JAL, 10 JALR, 11 reserved
in_fun3  input  3  condition code for conditional branches
operand_a  input  DataWidth  rs1 value
operand_b  input  DataWidth  rs2 value
in_pc  input  AddrWidth  instruction PC
in_imm  input  AddrWidth  sign-extended immediate
in_pred_taken  input  1  fetch prediction: taken
in_pred_target  input  AddrWidth  fetch predicted target
in_stall  input  1  hold the stage
in_flush  input  1  kill the stage
lk_pc  input  AddrWidth  fetch lookup PC
lk_taken  output  1  combinational prediction: MSB of the indexed counter
out_valid  output  1  registered result valid
out_taken  output  1  resolved direction
out_target  output  AddrWidth  resolved target
out_link  output  AddrWidth  in_pc+4
out_mispredict  output  1  fetch must be redirected
out_redirect_pc  output  AddrWidth  correct next PC
out_illegal  output  1  reserved kind, or fun3 010/011 on a conditional

Behaviour:
- Reset (async, rst_n=0):
  - All out_* registers are cleared to 0.
  - Every BHT counter is set to 2'b01 (weakly not-taken).
  - Reset asserted mid-operation discards any in-flight result.
- Latency: exactly 1 cycle. Inputs are sampled at a rising edge and outputs are valid after that edge.
- Priority at each edge:
  - in_flush=1: out_valid<=0, other out_* hold, no BHT update. This overrides in_stall.
  - else in_stall=1: all out_* hold, no BHT update.
  - else: out_valid<=in_valid and all other out_* load.
  - When in_valid=0, the other out_* still load but are don't-care.
- Conditional condition codes (fun3):
  - 000 eq, 001 ne.
  - 100 signed lt, 101 signed ge.
  - 110 unsigned lt, 111 unsigned ge.
  - 010/011 are illegal.
- Direction:
  - Legal conditional: taken = the condition result.
  - JAL/JALR: always taken.
  - Illegal or reserved: taken=0 and out_illegal=1.
- Target:
  - Conditional/JAL: in_pc+in_imm.
  - JALR: low AddrWidth bits of (operand_a + sign-extended in_imm), with bit 0 forced to 0.
  - All additions wrap modulo 2^AddrWidth; no overflow flag.
- Link: out_link = in_pc+4, wrapping.
- Mispredict:
  - out_mispredict = (taken != in_pred_taken) OR (taken AND target != in_pred_target).
  - out_redirect_pc = taken ? target : in_pc+4.
  - Illegal/reserved entries still produce a mispredict if in_pred_taken=1, redirecting to in_pc+4.
- BHT:
  - Index = pc[BhtIndexLsb +: log2(BhtEntries)], for both the lookup and the update.
  - Update happens only on an accepted (not flushed, not stalled), valid, legal conditional branch.
  - Taken: counter +1, saturating at 11. Not taken: counter -1, saturating at 00.
  - JAL, JALR and illegal entries never update.
- Lookup/update collision: if the lookup and update index match in the same cycle, lk_taken reflects the pre-update value. There is no bypass.

Test Plan:
- Reset, then lk_pc=0x100 -> lk_taken=0; all out_*=0; every counter reads 01.
- Conditional, fun3=100, a=0xFFFFFFFF, b=1, pc=0x100, imm=0x20, pred_taken=0 -> next cycle: out_valid=1, out_taken=1, out_target=0x120, out_mispredict=1, out_redirect_pc=0x120. Counter at index 0 goes 01->10 and lk_pc=0x100 then reads 1. The same operands with fun3=110 -> out_taken=0, out_redirect_pc=0x104.
- JALR: a=0x1003, imm=0x4, pred_taken=1, pred_target=0x1006 -> out_target=0x1006, out_link=pc+4, out_mispredict=0; BHT unchanged.
- Three taken branches at pc=0x200 then one not-taken -> counter 01->10->11->11->10; lk_taken=1 throughout the run of taken branches.
- in_stall=1 with a valid branch held for 3 cycles -> outputs hold the previous result and the BHT is unchanged. Asserting in_flush together with in_stall -> out_valid=0 on the next cycle.
- Conditional with fun3=010 and pred_taken=1 -> out_illegal=1, out_taken=0, out_mispredict=1, out_redirect_pc=pc+4, no BHT update. pc=0xFFFFFFFC, JAL imm=8 -> out_target=0x4, out_link=0x0 (wrap).
